// File: rtl/int_arbiter.sv
// rtl/int_arbiter.sv - interrupt arbiter sequencing one source at a time to the CPU
module int_arbiter #(
  parameter int NSRC = 16,
  parameter int VW   = 4
) (
  input  logic            Clk,
  input  logic            ResetN,
  input  logic [1:0]      Addr,
  output logic [15:0]     DataRd,
  input  logic [15:0]     DataWr,
  input  logic            En,
  input  logic            Rd,
  input  logic            Wr,
  input  logic [NSRC-1:0] IntReq,
  output logic [NSRC-1:0] IntReset,
  output logic            Int
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2,
    CLEAR   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [VW-1:0] vec, ptr, start, win, hi_win, lo_win;
  logic          hi_valid, lo_valid, win_valid;
  logic          enable, rr;
  logic          vec_rd, eoi_wr, ctrl_wr;
  logic          unused_bits;

  assign vec_rd      = En & Rd & (Addr == 2'd0);
  assign eoi_wr      = En & Wr & (Addr == 2'd1);
  assign ctrl_wr     = En & Wr & (Addr == 2'd3);
  assign unused_bits = ^DataWr[15:2];

  // Descending scan leaves the lowest set index overall (lo) and the lowest at or above start (hi).
  always_comb begin
    start    = rr ? ptr : '0;
    hi_win   = '0;
    lo_win   = '0;
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (IntReq[i]) begin
        lo_win   = VW'(i);
        lo_valid = 1'b1;
        if (VW'(i) >= start) begin
          hi_win   = VW'(i);
          hi_valid = 1'b1;
        end
      end
    end
    win       = hi_valid ? hi_win : lo_win;
    win_valid = lo_valid;
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && win_valid) state_nxt = PEND;
      PEND: begin
        if (vec_rd)                         state_nxt = SERVICE;
        else if (!IntReq[vec] || !enable)   state_nxt = IDLE;
      end
      SERVICE: if (eoi_wr) state_nxt = CLEAR;
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      vec    <= '0;
      ptr    <= '0;
      enable <= 1'b0;
      rr     <= 1'b0;
    end else begin
      if (state == IDLE && state_nxt == PEND) vec <= win;
      if (state == SERVICE && eoi_wr)
        ptr <= (vec == VW'(NSRC - 1)) ? '0 : vec + VW'(1);
      if (ctrl_wr) begin
        enable <= DataWr[0];
        rr     <= DataWr[1];
      end
    end
  end

  // Outputs decode the state register only, so IntReq never reaches Int combinationally.
  assign Int = (state == PEND);

  always_comb begin
    IntReset = '0;
    if (state == CLEAR) IntReset[vec] = 1'b1;
  end

  always_comb begin
    DataRd = '0;
    case (Addr)
      2'd0: begin
        if (state == PEND || state == SERVICE) begin
          DataRd[15]     = 1'b1;
          DataRd[VW-1:0] = vec;
        end
      end
      2'd2: begin
        DataRd[11:10]  = state;
        DataRd[VW-1:0] = ptr;
      end
      2'd3:    DataRd[1:0] = {rr, enable};
      default: DataRd = '0;
    endcase
  end

endmodule

// File: tb/tb_int_arbiter.sv
// tb/tb_int_arbiter.sv - table-driven scoreboard bench for int_arbiter
module tb_int_arbiter;

  typedef struct {
    string       name;
    logic        en, rd, wr;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] req;
    logic [15:0] exp_rd;
    logic [15:0] exp_irst;
    logic        exp_int;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] rd;
    logic [15:0] irst;
    logic        intr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  addr;
  logic [15:0] data_rd, data_wr, int_req, int_reset;
  logic        en, rd, wr, intr;

  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb[$];
  vec_t tbl[$];

  int_arbiter dut (
    .Clk(clk), .ResetN(rst_n), .Addr(addr), .DataRd(data_rd), .DataWr(data_wr),
    .En(en), .Rd(rd), .Wr(wr), .IntReq(int_req), .IntReset(int_reset), .Int(intr)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, want);
  endtask

  function automatic vec_t mk(input string n, input logic e, input logic r, input logic w,
                              input logic [1:0] a, input logic [15:0] d, input logic [15:0] q,
                              input logic [15:0] erd, input logic [15:0] eir, input logic ei);
    vec_t v;
    v.name = n; v.en = e; v.rd = r; v.wr = w; v.addr = a; v.wdata = d; v.req = q;
    v.exp_rd = erd; v.exp_irst = eir; v.exp_int = ei;
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 2ns later, well before the next rising edge.
  task automatic apply(input vec_t v);
    exp_t ex;
    @(negedge clk);
    en = v.en; rd = v.rd; wr = v.wr; addr = v.addr; data_wr = v.wdata; int_req = v.req;
    ex.name = v.name; ex.rd = v.exp_rd; ex.irst = v.exp_irst; ex.intr = v.exp_int;
    sb.push_back(ex);
    #2;
    ex = sb.pop_front();
    check({ex.name, ".rd"},   data_rd,   ex.rd);
    check({ex.name, ".irst"}, int_reset, ex.irst);
    check({ex.name, ".int"},  {15'd0, intr}, {15'd0, ex.intr});
  endtask

  function automatic int rr_winner(input logic [15:0] req, input int p);
    for (int off = 0; off < 16; off++) begin
      if (req[(p + off) % 16]) return (p + off) % 16;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 0; rd = 0; wr = 0; addr = 0; data_wr = 0; int_req = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ptr_m, g;
    logic [15:0] rq;

    //             name          en rd wr addr  wdata     req       exp_rd    exp_irst  int
    tbl.push_back(mk("rst_ctrl",  1, 1, 0, 2'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk("rst_stat",  0, 0, 0, 2'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk("ctrl_arb",  1, 0, 1, 2'd3, 16'h0001, 16'h0024, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk("idle_vec",  0, 0, 0, 2'd0, 16'h0000, 16'h0024, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk("pend_rd2",  1, 1, 0, 2'd0, 16'h0000, 16'h0024, 16'h8002, 16'h0000, 1));
    tbl.push_back(mk("svc_stat",  0, 0, 0, 2'd2, 16'h0000, 16'h0024, 16'h0800, 16'h0000, 0));
    tbl.push_back(mk("eoi2",      1, 0, 1, 2'd1, 16'h0000, 16'h0024, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk("clear2",    0, 0, 0, 2'd2, 16'h0000, 16'h0020, 16'h0C03, 16'h0004, 0));
    tbl.push_back(mk("idle_p3",   0, 0, 0, 2'd2, 16'h0000, 16'h0020, 16'h0003, 16'h0000, 0));
    tbl.push_back(mk("eoi_pend",  1, 0, 1, 2'd1, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 1));
    tbl.push_back(mk("pend_stat", 0, 0, 0, 2'd2, 16'h0000, 16'h0020, 16'h0403, 16'h0000, 1));
    tbl.push_back(mk("pend_rd5",  1, 1, 0, 2'd0, 16'h0000, 16'h0020, 16'h8005, 16'h0000, 1));
    tbl.push_back(mk("svc_dis",   1, 0, 1, 2'd3, 16'h0000, 16'h0020, 16'h0001, 16'h0000, 0));
    tbl.push_back(mk("svc_hold",  0, 0, 0, 2'd2, 16'h0000, 16'h0020, 16'h0803, 16'h0000, 0));
    tbl.push_back(mk("eoi5",      1, 0, 1, 2'd1, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk("clear5",    0, 0, 0, 2'd2, 16'h0000, 16'h0000, 16'h0C06, 16'h0020, 0));
    tbl.push_back(mk("idle_dis",  0, 0, 0, 2'd2, 16'h0000, 16'h0010, 16'h0006, 16'h0000, 0));
    tbl.push_back(mk("eoi_idle",  1, 0, 1, 2'd1, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk("ctrl_en",   1, 0, 1, 2'd3, 16'h0001, 16'h0010, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk("idle_arb4", 0, 0, 0, 2'd2, 16'h0000, 16'h0010, 16'h0006, 16'h0000, 0));
    tbl.push_back(mk("withdraw",  0, 0, 0, 2'd0, 16'h0000, 16'h0000, 16'h8004, 16'h0000, 1));
    tbl.push_back(mk("wd_idle",   0, 0, 0, 2'd2, 16'h0000, 16'h0010, 16'h0006, 16'h0000, 0));
    tbl.push_back(mk("rd_drop",   1, 1, 0, 2'd0, 16'h0000, 16'h0000, 16'h8004, 16'h0000, 1));
    tbl.push_back(mk("svc_rd",    1, 1, 0, 2'd0, 16'h0000, 16'h0000, 16'h8004, 16'h0000, 0));
    tbl.push_back(mk("eoi4",      1, 0, 1, 2'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk("clear4",    0, 0, 0, 2'd2, 16'h0000, 16'h0000, 16'h0C05, 16'h0010, 0));
    tbl.push_back(mk("idle_p5",   0, 0, 0, 2'd2, 16'h0000, 16'h0100, 16'h0005, 16'h0000, 0));
    tbl.push_back(mk("pend_dis",  1, 0, 1, 2'd3, 16'h0000, 16'h0100, 16'h0001, 16'h0000, 1));
    tbl.push_back(mk("pend_st8",  0, 0, 0, 2'd2, 16'h0000, 16'h0100, 16'h0405, 16'h0000, 1));
    tbl.push_back(mk("dis_idle",  0, 0, 0, 2'd2, 16'h0000, 16'h0100, 16'h0005, 16'h0000, 0));

    rst_n = 1'b0;
    do_reset();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Round-robin with two requests held: grants alternate and Ptr wraps 15 -> 0.
    do_reset();
    rq = 16'h8001;
    apply(mk("rr_ctrl", 1, 0, 1, 2'd3, 16'h0003, rq, 16'h0000, 16'h0000, 0));
    ptr_m = 0;
    for (int k = 0; k < 4; k++) begin
      g = rr_winner(rq, ptr_m);
      apply(mk($sformatf("rr%0d_idle", k), 0, 0, 0, 2'd2, 16'h0000, rq, 16'(ptr_m), 16'h0000, 0));
      apply(mk($sformatf("rr%0d_vec", k), 1, 1, 0, 2'd0, 16'h0000, rq, 16'h8000 | 16'(g), 16'h0000, 1));
      apply(mk($sformatf("rr%0d_eoi", k), 1, 0, 1, 2'd1, 16'h0000, rq, 16'h0000, 16'h0000, 0));
      ptr_m = (g + 1) % 16;
      apply(mk($sformatf("rr%0d_clr", k), 0, 0, 0, 2'd2, 16'h0000, rq, 16'h0C00 | 16'(ptr_m),
               16'h0001 << g, 0));
    end

    // Reset during the EOI cycle of a service: the pending IntReset pulse must never appear.
    apply(mk("rs_idle", 0, 0, 0, 2'd2, 16'h0000, rq, 16'h0000, 16'h0000, 0));
    apply(mk("rs_vec",  1, 1, 0, 2'd0, 16'h0000, rq, 16'h8000, 16'h0000, 1));
    apply(mk("rs_svc",  0, 0, 0, 2'd2, 16'h0000, rq, 16'h0800, 16'h0000, 0));
    @(negedge clk);
    en = 1; wr = 1; rd = 0; addr = 2'd1;
    #2 rst_n = 1'b0;
    #1;
    check("rs_async.int",  {15'd0, intr}, 16'h0000);
    check("rs_async.irst", int_reset, 16'h0000);
    addr = 2'd2;
    #1 check("rs_async.stat", data_rd, 16'h0000);
    addr = 2'd3;
    #1 check("rs_async.ctrl", data_rd, 16'h0000);
    en = 0; wr = 0;
    @(negedge clk);
    check("rs_held.irst", int_reset, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("rs_after.irst", int_reset, 16'h0000);
    check("rs_after.int",  {15'd0, intr}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/int_arbiter.md
Name: int_arbiter

Overview:
- Sequences interrupt delivery from the interrupt controller's filtered request vector to the CPU, one source at a time.
- Arbitrates pending sources by fixed priority or round-robin and presents a vector register to the CPU.
- Tracks the in-service source and issues a one-cycle IntReset pulse to that source on end-of-interrupt (EOI).
- Sits between the interrupt controller's status/mask output and the CPU bus, on the same 16-bit register bus.

Parameters:
- NSRC, 16, number of request sources (2..16)
- VW, 4, vector index width, ceil(log2(NSRC))

Ports:
- Clk  in  1  system clock, rising edge
- ResetN  in  1  asynchronous, active-low reset
- Addr  in  2  register select
- DataRd  out  16  read data, combinational from Addr and state
- DataWr  in  16  write data
- En  in  1  block select
- Rd  in  1  read strobe, qualified by En
- Wr  in  1  write strobe, qualified by En
- IntReq  in  NSRC  level requests, already masked
- IntReset  out  NSRC  one-hot clear pulse to the source
- Int  out  1  CPU interrupt line

Behaviour:
- Reset (ResetN=0, asynchronous):
  - State=IDLE, Vec=0, Ptr=0, CtrlEnable=0, CtrlRR=0.
  - IntReset=0, Int=0.
- Registers:
  - Addr0 VECTOR (read): {Valid[15], 0[14:VW], Vec}. Valid=1 in PEND and SERVICE, otherwise reads 0x0000.
  - Addr1 EOI (write): data ignored.
  - Addr2 STATUS (read): {0[15:12], State[11:10], 0[9:VW], Ptr}. Encoding IDLE=0, PEND=1, SERVICE=2, CLEAR=3.
  - Addr3 CTRL (read/write): bit0=Enable, bit1=RR. Other bits read 0.
- Winner selection (combinational over IntReq):
  - Fixed mode (RR=0): lowest set index wins.
  - RR mode: first set index at or above Ptr, wrapping modulo NSRC.
- State machine, all transitions on the rising edge of Clk:
  - IDLE: if Enable and IntReq!=0, latch the winner into Vec and go to PEND.
  - PEND: Int=1 (decoded from the state register, so no combinational path from IntReq).
    - VECTOR read (En&Rd&Addr==0) -> SERVICE.
    - Otherwise, if IntReq[Vec]==0 (spurious withdrawal) or Enable==0 -> IDLE.
    - Read and withdrawal in the same cycle: the read wins, go to SERVICE.
  - SERVICE: Int=0.
    - EOI write (En&Wr&Addr==1) -> CLEAR, with IntReset[Vec]=1 for exactly that next cycle.
    - Set Ptr=(Vec+1) mod NSRC, in both modes.
    - Disable does not leave SERVICE.
  - CLEAR: lasts one cycle, during which IntReset pulses. No arbitration, so a stale request is not re-granted. -> IDLE.
- Boundary rules:
  - EOI in any state other than SERVICE is ignored.
  - VECTOR reads outside PEND have no side effect.
  - A CTRL write in the same cycle as an IDLE arbitration: arbitration uses the old Enable.
  - Ptr wraps from NSRC-1 to 0.
  - Vec and IntReset stay stable for a full service. Vec changes only on IDLE->PEND.
- Latency:
  - Request in cycle N (IDLE, enabled) -> Int high from N+1.
  - Minimum request-to-next-grant turnaround after EOI is 2 cycles (CLEAR, IDLE).
- Reset asserted mid-service: state returns to IDLE immediately. Any IntReset pulse in flight is dropped.

Test Plan:
- Reset, then CTRL=0x0001 and IntReq=0x0024 -> PEND next cycle, Int=1. VECTOR read=0x8002; Int=0 the cycle after.
- From that SERVICE, write EOI -> IntReset=0x0004 for exactly 1 cycle. STATUS shows CLEAR then IDLE, Ptr=3. IntReq=0x0020 then grants Vec=5.
- RR mode (CTRL=0x0003), IntReq=0x8001 held, four full read/EOI loops -> grant order 0,15,0,15. Ptr wraps 0 to 1 to 0 correctly.
- PEND on Vec=4, drop IntReq[4] without a read -> IDLE next cycle, Int=0, no IntReset. A read in the same cycle as the drop -> SERVICE, VECTOR returns 0x8004.
- EOI written in IDLE or PEND -> no IntReset, state unchanged. CTRL=0x0000 written in SERVICE -> stays SERVICE until EOI.
- Drive ResetN low while in SERVICE, one cycle before an IntReset pulse -> Int=0 and IntReset=0 immediately, STATUS=0x0000, CTRL reads 0.
